sequence_verifier: RTL and testbench

Checks the player's button sequence against the stored bomb-defusal pattern and reports the outcome to the game controller on `s_results`. It sits directly upstream of the game controller and consumes that block's `s_current` state code. Each round is Simon-style: round r requires the first r+1 pattern symbols. The block also drives the pass/fail hold and the hand-back codes that move the controller between its states.

---
 rtl/sequence_verifier.sv | 82 ++++++++
 tb/tb_sequence_verifier.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sequence_verifier.sv
// sequence_verifier: Simon-style pattern checker driving pass/fail holds and hand-back codes to the game controller
module sequence_verifier #(
  parameter int MAX_LEN     = 8,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_current,
  input  logic [3:0]             btn,
  input  logic [2*MAX_LEN-1:0]   pattern,
  output logic [1:0]             s_results,
  output logic [3:0]             round,
  output logic [3:0]             progress
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ENTRY, PASS_HOLD, PASS_DONE, FAIL_HOLD, FAIL_DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic valid, hit, last, hold_end;
  logic [1:0] sym, want;
  always_comb begin
    valid = btn != 4'd0 && (btn & (btn - 4'd1)) == 4'd0;
    sym = btn[3] ? 2'd3 : btn[2] ? 2'd2 : btn[1] ? 2'd1 : 2'd0;
    want = 2'(pattern >> {progress, 1'b0});
    hit = valid && sym == want;
    last = progress == round;
    hold_end = cnt == CW'(HOLD_CYCLES - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      s_results <= 2'b00;
      round <= 4'd0;
      progress <= 4'd0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (s_current == 8'h10) state <= ENTRY;
        ENTRY: begin
          if (s_current == 8'h30 || (valid && !hit)) begin
            state <= FAIL_HOLD;
            s_results <= 2'b10;
            cnt <= '0;
          end else if (hit && last) begin
            state <= PASS_HOLD;
            s_results <= 2'b01;
            cnt <= '0;
          end else if (hit) progress <= progress + 4'd1;
        end
        PASS_HOLD: begin
          if (hold_end) begin
            state <= PASS_DONE;
            s_results <= 2'b11;
          end else cnt <= cnt + 1'b1;
        end
        PASS_DONE: begin
          if (s_current == 8'h10) begin
            state <= ENTRY;
            s_results <= 2'b00;
            progress <= 4'd0;
            round <= round == 4'(MAX_LEN - 1) ? 4'd0 : round + 4'd1;
          end
        end
        FAIL_HOLD: begin
          if (hold_end) begin
            state <= FAIL_DONE;
            s_results <= 2'b11;
          end else cnt <= cnt + 1'b1;
        end
        FAIL_DONE: begin
          if (s_current == 8'h00) begin
            state <= IDLE;
            s_results <= 2'b00;
            round <= 4'd0;
            progress <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sequence_verifier.sv
// tb_sequence_verifier: directed plus random stimulus scored against a round-level reference model
module tb_sequence_verifier;
  localparam int ML = 3, HC = 4;
  logic clk = 0, rst = 0;
  logic [7:0] s_current = 0;
  logic [3:0] btn = 0;
  logic [2*ML-1:0] pattern = 0, pat_next = 0;
  logic [1:0] s_results;
  logic [3:0] round, progress;
  typedef struct { logic [1:0] res; logic [3:0] rnd; logic [3:0] prg; int ph; } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, phase = 0;
  int m_res = 0, m_round = 0, m_prog = 0, m_left = 0;
  bit m_play = 0, m_passed = 0;

  sequence_verifier #(.MAX_LEN(ML), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .s_current(s_current), .btn(btn), .pattern(pattern),
    .s_results(s_results), .round(round), .progress(progress)
  );

  always #5 clk = ~clk;

  function automatic int sym_at(int i);
    return int'(pattern >> (2 * i)) & 3;
  endfunction

  task automatic finish_round(input bit p);
    m_res = p ? 1 : 2;
    m_passed = p;
    m_left = HC;
  endtask

  task automatic model_step(input bit r, input logic [7:0] sc, input logic [3:0] b);
    int s = 0;
    int len = (m_round + 1 < ML) ? m_round + 1 : ML;
    for (int k = 0; k < 4; k++) if (b[k]) s = k;
    if (!r) begin
      m_res = 0; m_round = 0; m_prog = 0; m_play = 0;
    end else if (m_res == 1 || m_res == 2) begin
      m_left--;
      if (m_left == 0) m_res = 3;
    end else if (m_res == 3) begin
      if (m_passed && sc == 8'h10) begin
        m_res = 0; m_prog = 0; m_round = (m_round + 1) % ML; m_play = 1;
      end else if (!m_passed && sc == 8'h00) begin
        m_res = 0; m_round = 0; m_prog = 0; m_play = 0;
      end
    end else if (!m_play) m_play = sc == 8'h10;
    else if (sc == 8'h30) finish_round(0);
    else if ($countones(b) == 1) begin
      if (s != sym_at(m_prog)) finish_round(0);
      else if (m_prog == len - 1) finish_round(1);
      else m_prog++;
    end
    q.push_back('{2'(m_res), 4'(m_round), 4'(m_prog), phase});
  endtask

  task automatic cyc(input bit r, input logic [7:0] sc, input logic [3:0] b);
    @(negedge clk);
    pattern = pat_next;
    rst = r;
    s_current = sc;
    btn = b;
    model_step(r, sc, b);
  endtask

  task automatic press(input int s, input logic [7:0] sc = 8'h10);
    cyc(1, sc, 4'(1 << s));
  endtask

  task automatic wait_n(input int n, input logic [7:0] sc);
    repeat (n) cyc(1, sc, 4'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({s_results, round, progress} !== {e.res, e.rnd, e.prg}) begin
        failures++;
        $display("FAIL ph%0d outputs got res=%b round=%0d prog=%0d want res=%b round=%0d prog=%0d",
                 e.ph, s_results, round, progress, e.res, e.rnd, e.prg);
      end
    end
  end

  initial begin
    int x, y;
    bit in_entry;
    logic [7:0] sc;
    logic [3:0] b;
    phase = 0;
    pat_next = {2'd0, 2'd3, 2'd2};
    cyc(0, 8'h00, 4'd0);
    cyc(0, 8'h00, 4'd0);
    phase = 1;
    cyc(1, 8'h10, 4'd0);
    press(2);
    wait_n(5, 8'h20);
    pat_next = {2'd0, 2'd3, 2'd1};
    cyc(1, 8'h10, 4'd0);
    phase = 2;
    press(1); press(3);
    wait_n(5, 8'h20);
    cyc(1, 8'h10, 4'd0);
    press(1); press(3); press(0);
    wait_n(5, 8'h20);
    cyc(1, 8'h10, 4'd0);
    phase = 3;
    press(1);
    wait_n(5, 8'h20);
    cyc(1, 8'h10, 4'd0);
    press(1); press(2);
    wait_n(6, 8'h30);
    cyc(1, 8'h00, 4'd0);
    phase = 4;
    cyc(1, 8'h10, 4'd0);
    press(1);
    wait_n(5, 8'h20);
    cyc(1, 8'h10, 4'd0);
    press(1);
    press(3, 8'h30);
    wait_n(6, 8'h30);
    cyc(1, 8'h00, 4'd0);
    phase = 5;
    cyc(1, 8'h10, 4'd0);
    cyc(1, 8'h10, 4'b0110);
    press(1);
    press(1);
    wait_n(4, 8'h20);
    cyc(1, 8'h10, 4'd0);
    press(0);
    cyc(1, 8'h30, 4'd0);
    cyc(0, 8'h30, 4'd0);
    wait_n(2, 8'h00);
    phase = 6;
    for (int i = 0; i < 3000; i++) begin
      x = $urandom_range(0, 99);
      sc = x < 55 ? 8'h10 : x < 58 ? 8'h30 : x < 80 ? 8'h00 : x < 90 ? 8'h20 : 8'($urandom);
      in_entry = m_play && m_res == 0;
      y = $urandom_range(0, 9);
      b = (in_entry && y < 5) ? 4'(1 << sym_at(m_prog)) :
          y < 7 ? 4'(1 << $urandom_range(0, 3)) : y < 8 ? 4'($urandom) : 4'd0;
      if (!in_entry && $urandom_range(0, 9) == 0) pat_next = (2*ML)'($urandom);
      cyc($urandom_range(0, 299) != 0, sc, b);
    end
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
